axil_regbank: RTL and testbench
===============================

Name: axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank.
- Generalises the fixed four-register 32-bit test peripheral to:
  - N read/write control registers and M read-only status registers;
  - byte-strobe writes;
  - SLVERR decode;
  - per-register write pulses.
- Sits behind the interconnect as the standard control/status endpoint for custom IP.

Parameters:
- DATA_WIDTH, 32, AXI data width; 32 or 64.
- ADDR_WIDTH, 8, AXI address width; byte addressed.
- NUM_RW, 12, number of read/write registers, indices 0..NUM_RW-1.
- NUM_RO, 4, number of read-only status registers, indices NUM_RW..NUM_RW+NUM_RO-1.
- RESET_VAL, 0, reset value of every RW register.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- ctrl_out  out  NUM_RW*DATA_WIDTH  flattened RW register contents; register k at [k*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_RW  one-cycle strobe per RW register on a successful write.
- status_in  in  NUM_RO*DATA_WIDTH  flattened status values, sampled on read.
- irq  out  1  interrupt; present only with the optional feature, tied 0 otherwise.

Behaviour:
- Clock and reset:
  - ACLK and ARESETN: single clock; reset asynchronous assert, synchronous deassert by the system.
  - Reset values: all READY/VALID 0, BRESP/RRESP 0, RDATA 0, wr_pulse 0, RW registers = RESET_VAL.
- Address decode:
  - ADDR_LSB = clog2(DATA_WIDTH/8); index = addr[ADDR_WIDTH-1:ADDR_LSB].
  - Low address bits are ignored.
- Write FSM has states W_IDLE, W_RESP.
  - In W_IDLE, AWREADY and WREADY are high for each channel not yet captured.
  - AW and W are accepted in any order or in the same cycle, and each is latched independently.
  - Once both are held: perform the write, drop both READYs, assert BVALID, go to W_RESP.
  - BVALID rises the cycle after the second handshake.
  - W_RESP holds BVALID and BRESP stable until BREADY, then returns to W_IDLE. No new AW/W is accepted while in W_RESP.
- Write effect:
  - For each byte b with WSTRB[b]=1, reg[index] byte b <= WDATA byte b.
  - wr_pulse[index]=1 for exactly one cycle, coincident with the register update.
  - WSTRB=0 is OKAY, with wr_pulse asserted and no data change.
- Write errors:
  - index >= NUM_RW (RO region or unmapped) gives BRESP=SLVERR (2'b10), no register change, no wr_pulse.
- Read FSM has states R_IDLE, R_DATA.
  - ARREADY is high in R_IDLE; on handshake, RDATA/RRESP are registered and RVALID rises the next cycle.
  - R_DATA holds RDATA/RRESP stable until RREADY, then returns to R_IDLE.
  - Throughput: one read per two cycles minimum.
- Read data:
  - RW index returns the register value.
  - RO index returns the status_in slice sampled in the AR handshake cycle.
  - index >= NUM_RW+NUM_RO returns RDATA=0, RRESP=SLVERR.
- Read and write are independent and may overlap. A read of a register written in the same cycle returns the pre-write value.
- Reset mid-transaction aborts both FSMs to idle, drops all VALIDs immediately and discards latched AW/W.

Optional Feature:
- Macro AXIL_REGBANK_IRQ_EN.
- When defined:
  - An extra register sits at index NUM_RW+NUM_RO with sticky pending bits [NUM_RO-1:0].
  - Bit k sets on a rising edge of status_in slice k bit 0 (edge detect with one flop).
  - Writing 1 to a bit clears it (W1C, honouring WSTRB); set wins over clear in the same cycle.
  - irq = OR of pending bits, registered.
  - Reads at this index are OKAY.
- When undefined: the index is unmapped (SLVERR), irq is tied 0, and there is no edge-detect logic.

Decomposition:
- Package axil_regbank_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - enums wr_state_t {W_IDLE,W_RESP} and rd_state_t {R_IDLE,R_DATA};
  - function for ADDR_LSB.
- The one natural sub-module is axil_regbank_decode, combinational index/region decode shared by both channels (RW, RO, IRQ, unmapped).

Test Plan:
- Reset, write 0x1..0x4 to indices 0..3 with WSTRB=0xF, read back -> RDATA 0x1..0x4, OKAY, wr_pulse[0..3] each seen once.
- Partial write:
  - reg2=0xAABBCCDD, then write 0x11223344 with WSTRB=0x5 -> read 0xAA22CC44.
  - wr_pulse[2] is asserted once.
- AW issued 3 cycles before W, then W 3 cycles before AW, then both in the same cycle -> exactly one write and one BVALID each; BVALID held 4 cycles under BREADY=0 with stable BRESP.
- Errors:
  - Write to index NUM_RW (RO) -> SLVERR, status unchanged.
  - Read index 20 with defaults -> RDATA 0, SLVERR.
  - Read index 13 with status_in slice 1 = 0xDEADBEEF -> 0xDEADBEEF, OKAY.
- ARESETN low while BVALID and RVALID are pending -> both VALIDs 0 immediately; after release, a read of reg0 returns RESET_VAL.
- With AXIL_REGBANK_IRQ_EN:
  - Pulse status slice 0 bit 0 high -> irq=1.
  - Write 0x1 to index 16 -> irq=0.
  - Edge and clear in the same cycle -> bit stays set.

Source files
------------

// File: rtl/axil_regbank_pkg.sv
// Shared types and constants for the axil_regbank AXI4-Lite register bank.
// Covers response codes, the write/read FSM states and the decoded address regions.
package axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        REG_RW,
        REG_RO,
        REG_IRQ,
        REG_UNMAPPED
    } region_t;

    // Number of byte-offset bits below the register index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_regbank_decode.sv
// Combinational address decode for axil_regbank: register index and region.
// The IRQ region exists only when AXIL_REGBANK_IRQ_EN is defined.
module axil_regbank_decode
    import axil_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RW     = 12,
    parameter int NUM_RO     = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           reg_index,
    output region_t               region
);

    localparam int          ADDR_LSB  = addr_lsb(DATA_WIDTH);
    localparam int unsigned RO_BASE   = NUM_RW;
    localparam int unsigned RO_END    = NUM_RW + NUM_RO;
    localparam int unsigned IRQ_INDEX = NUM_RW + NUM_RO;

    // Byte offset within a register carries no meaning for this bank.
    logic unused_low;
    assign unused_low = ^addr[ADDR_LSB-1:0];

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        reg_index = 32'(addr[ADDR_WIDTH-1:ADDR_LSB]);
        if (reg_index < RO_BASE) begin
            region = REG_RW;
        end else if (reg_index < RO_END) begin
            region = REG_RO;
`ifdef AXIL_REGBANK_IRQ_EN
        end else if (reg_index == IRQ_INDEX) begin
            region = REG_IRQ;
`endif
        end else begin
            region = REG_UNMAPPED;
        end
    end

endmodule

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite slave with NUM_RW control and NUM_RO status registers.
// Define AXIL_REGBANK_IRQ_EN to add a sticky W1C pending register and the irq output.
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    NUM_RW     = 12,
    parameter int                    NUM_RO     = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_RW-1:0]            wr_pulse,
    input  logic [NUM_RO*DATA_WIDTH-1:0] status_in,
    output logic                         irq
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // ---------------------------------------------------------------- write
    wr_state_t               wr_state;
    logic                    aw_held, w_held;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_WIDTH-1:0]   w_strb_q;
    logic                    aw_ready, w_ready, b_valid;
    logic [1:0]              b_resp;

    logic                    aw_hs, w_hs, aw_have, w_have, wr_fire, wr_rw;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data, wr_mask;
    logic [STRB_WIDTH-1:0]   wr_strb;
    logic [31:0]             wr_index;
    region_t                 wr_region;

    assign aw_hs   = S_AXI_AWVALID && aw_ready;
    assign w_hs    = S_AXI_WVALID && w_ready;
    assign aw_have = aw_held || aw_hs;
    assign w_have  = w_held || w_hs;
    assign wr_fire = (wr_state == W_IDLE) && aw_have && w_have;

    // A channel captured in an earlier cycle takes precedence over the live bus.
    assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
    assign wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;

    for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_mask
        assign wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end

    axil_regbank_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_RW     (NUM_RW),
        .NUM_RO     (NUM_RO)
    ) u_wr_decode (
        .addr      (wr_addr),
        .reg_index (wr_index),
        .region    (wr_region)
    );

    assign wr_rw = wr_fire && (wr_region == REG_RW);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state  <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            aw_ready  <= 1'b0;
            w_ready   <= 1'b0;
            b_valid   <= 1'b0;
            b_resp    <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= S_AXI_AWADDR;
                    end
                    if (w_hs) begin
                        w_data_q <= S_AXI_WDATA;
                        w_strb_q <= S_AXI_WSTRB;
                    end
                    if (wr_fire) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b0;
                        b_valid  <= 1'b1;
                        b_resp   <= (wr_region == REG_RW || wr_region == REG_IRQ)
                                    ? RESP_OKAY : RESP_SLVERR;
                        wr_state <= W_RESP;
                    end else begin
                        aw_held  <= aw_have;
                        w_held   <= w_have;
                        aw_ready <= !aw_have;
                        w_ready  <= !w_have;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;

    // ------------------------------------------------------- RW registers
    for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
        logic [DATA_WIDTH-1:0] reg_q;
        logic                  pulse_q;
        logic                  hit;

        assign hit = wr_rw && (wr_index == k);

        // NOTE: the bank is reset to RESET_VAL because software may read before it writes.
        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                reg_q   <= RESET_VAL;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= hit;
                if (hit) begin
                    reg_q <= (reg_q & ~wr_mask) | (wr_data & wr_mask);
                end
            end
        end

        assign ctrl_out[k*DATA_WIDTH +: DATA_WIDTH] = reg_q;
        assign wr_pulse[k] = pulse_q;
    end

    // ------------------------------------------------------ interrupt pending
`ifdef AXIL_REGBANK_IRQ_EN
    logic [NUM_RO-1:0] status_bit0, status_prev, pending;
    logic [NUM_RO-1:0] pending_set, pending_clr, pending_next;
    logic              irq_q;

    for (genvar k = 0; k < NUM_RO; k++) begin : g_edge
        assign status_bit0[k] = status_in[k*DATA_WIDTH];
    end

    // A new edge in the clearing cycle must not be lost, so set is applied last.
    assign pending_set  = status_bit0 & ~status_prev;
    assign pending_clr  = (wr_fire && wr_region == REG_IRQ)
                          ? (wr_data[NUM_RO-1:0] & wr_mask[NUM_RO-1:0]) : '0;
    assign pending_next = (pending & ~pending_clr) | pending_set;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            status_prev <= '0;
            pending     <= '0;
            irq_q       <= 1'b0;
        end else begin
            status_prev <= status_bit0;
            pending     <= pending_next;
            irq_q       <= |pending_next;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // ----------------------------------------------------------------- read
    rd_state_t             rd_state;
    logic                  ar_ready, r_valid;
    logic [1:0]            r_resp;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  ar_hs;
    logic [31:0]           rd_index;
    region_t               rd_region;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic [1:0]            rd_resp_c;

    assign ar_hs = S_AXI_ARVALID && ar_ready;

    axil_regbank_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_RW     (NUM_RW),
        .NUM_RO     (NUM_RO)
    ) u_rd_decode (
        .addr      (S_AXI_ARADDR),
        .reg_index (rd_index),
        .region    (rd_region)
    );

    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        case (rd_region)
            REG_RW: begin
                for (int k = 0; k < NUM_RW; k++) begin
                    if (rd_index == k) rd_data_c = ctrl_out[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            REG_RO: begin
                for (int k = 0; k < NUM_RO; k++) begin
                    if (rd_index == NUM_RW + k) rd_data_c = status_in[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`ifdef AXIL_REGBANK_IRQ_EN
            REG_IRQ: rd_data_c = DATA_WIDTH'(pending);
`endif
            default: rd_resp_c = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_data   <= rd_data_c;
                        r_resp   <= rd_resp_c;
                        r_valid  <= 1'b1;
                        ar_ready <= 1'b0;
                        rd_state <= R_DATA;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_valid  <= 1'b0;
                        ar_ready <= 1'b1;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = r_resp;

endmodule

// File: tb/tb_axil_regbank.sv
// Scoreboard bench for axil_regbank: directed cases plus random traffic against a
// register-level reference model. Define AXIL_REGBANK_IRQ_EN to cover the pending register.
module tb_axil_regbank;

    localparam int         DW      = 32;
    localparam int         AW      = 8;
    localparam int         NUM_RW  = 12;
    localparam int         NUM_RO  = 4;
    localparam int         IRQ_IDX = NUM_RW + NUM_RO;
    localparam int         TIMEOUT = 64;
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;
`ifdef AXIL_REGBANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic               clk, rst_n;
    logic [AW-1:0]      awaddr, araddr;
    logic               awvalid, awready, wvalid, wready, bvalid, bready;
    logic               arvalid, arready, rvalid, rready;
    logic [DW-1:0]      wdata, rdata;
    logic [DW/8-1:0]    wstrb;
    logic [1:0]         bresp, rresp;
    logic [NUM_RW*DW-1:0] ctrl_out;
    logic [NUM_RW-1:0]  wr_pulse;
    logic [NUM_RO*DW-1:0] status_flat;
    logic               irq;
    logic [DW-1:0]      status_arr [NUM_RO];

    always_comb begin
        status_flat = '0;
        for (int k = 0; k < NUM_RO; k++) status_flat[k*DW +: DW] = status_arr[k];
    end

    axil_regbank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RW     (NUM_RW),
        .NUM_RO     (NUM_RO),
        .RESET_VAL  ('0)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_out      (ctrl_out),
        .wr_pulse      (wr_pulse),
        .status_in     (status_flat),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0]     model_rw [NUM_RW];
    logic [NUM_RO-1:0] model_pending;
    int                exp_pulse [NUM_RW];
    int                pulse_cnt [NUM_RW];
    logic [1:0]        exp_b [$];
    logic [33:0]       exp_r [$];
    int                b_done = 0;
    int                r_done = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: no response within %0d cycles", name, TIMEOUT);
    endtask

    function automatic logic [33:0] expect_read(input int idx);
        if (idx < NUM_RW) return {OKAY, model_rw[idx]};
        if (idx < NUM_RW + NUM_RO) return {OKAY, status_arr[idx - NUM_RW]};
        if (IRQ_EN && idx == IRQ_IDX) return {OKAY, 28'h0, model_pending};
        return {SLVERR, 32'h0};
    endfunction

    function automatic logic [1:0] expect_bresp(input int idx);
        if (idx < NUM_RW) return OKAY;
        if (IRQ_EN && idx == IRQ_IDX) return OKAY;
        return SLVERR;
    endfunction

    // Register-level meaning of one completed write.
    function automatic void model_commit(input int idx, input logic [31:0] data, input logic [3:0] strb);
        if (idx < NUM_RW) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_rw[idx][8*b +: 8] = data[8*b +: 8];
            exp_pulse[idx]++;
        end else if (IRQ_EN && idx == IRQ_IDX) begin
            for (int j = 0; j < NUM_RO; j++)
                if (strb[j/8] && data[j]) model_pending[j] = 1'b0;
        end
    endfunction

    function automatic int sum(input int a [NUM_RW]);
        int s = 0;
        for (int k = 0; k < NUM_RW; k++) s += a[k];
        return s;
    endfunction

    // Monitor: compares responses whenever the DUT completes a B or R handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_unexpected: BVALID with no write outstanding, bresp=%0d", bresp);
                end else begin
                    check("bresp", bresp, exp_b.pop_front());
                end
                b_done++;
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    $display("FAIL r_unexpected: RVALID with no read outstanding, rdata=0x%0h", rdata);
                end else begin
                    logic [33:0] e;
                    e = exp_r.pop_front();
                    check("rdata", rdata, e[31:0]);
                    check("rresp", rresp, e[33:32]);
                end
                r_done++;
            end
            for (int k = 0; k < NUM_RW; k++) if (wr_pulse[k]) pulse_cnt[k]++;
        end
    end

    // -------------------------------------------------------------- drivers
    task automatic send_write(input logic [AW-1:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int aw_dly, input int w_dly);
        exp_b.push_back(expect_bresp(int'(addr >> 2)));
        fork
            begin
                int t = 0;
                repeat (aw_dly) begin @(posedge clk); #1; end
                awaddr = addr; awvalid = 1'b1;
                do begin @(negedge clk); t++; end while (!awready && t < TIMEOUT);
                if (!awready) timeout_fail("aw_handshake");
                @(posedge clk); #1;
                awvalid = 1'b0;
            end
            begin
                int t = 0;
                repeat (w_dly) begin @(posedge clk); #1; end
                wdata = data; wstrb = strb; wvalid = 1'b1;
                do begin @(negedge clk); t++; end while (!wready && t < TIMEOUT);
                if (!wready) timeout_fail("w_handshake");
                @(posedge clk); #1;
                wvalid = 1'b0;
            end
        join
    endtask

    task automatic wait_b();
        int start = b_done;
        int t = 0;
        while (b_done == start && t < TIMEOUT) begin @(posedge clk); #1; t++; end
        if (b_done == start) timeout_fail("b_response");
    endtask

    task automatic wait_r();
        int start = r_done;
        int t = 0;
        while (r_done == start && t < TIMEOUT) begin @(posedge clk); #1; t++; end
        if (r_done == start) timeout_fail("r_response");
    endtask

    task automatic write_reg(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        int idx = int'(addr >> 2);
        send_write(addr, data, strb, aw_dly, w_dly);
        wait_b();
        model_commit(idx, data, strb);
        if (idx < NUM_RW) begin
            check($sformatf("ctrl_out[%0d]", idx), ctrl_out[idx*DW +: DW], model_rw[idx]);
            check($sformatf("wr_pulse_cnt[%0d]", idx), pulse_cnt[idx], exp_pulse[idx]);
        end
        check("wr_pulse_total", sum(pulse_cnt), sum(exp_pulse));
    endtask

    task automatic send_ar(input logic [AW-1:0] addr);
        int t = 0;
        araddr = addr; arvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!arready && t < TIMEOUT);
        if (!arready) timeout_fail("ar_handshake");
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic read_reg(input logic [AW-1:0] addr);
        exp_r.push_back(expect_read(int'(addr >> 2)));
        send_ar(addr);
        wait_r();
    endtask

    task automatic check_ctrl_all(input string name);
        for (int k = 0; k < NUM_RW; k++)
            check($sformatf("%s[%0d]", name, k), ctrl_out[k*DW +: DW], model_rw[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_RW; k++) model_rw[k] = '0;
        model_pending = '0;
        exp_b.delete();
        exp_r.delete();
    endtask

    // Raise then drop status slice 0 bit 0; with the pending register this sets bit 0.
    task automatic pulse_status0();
        status_arr[0][0] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        status_arr[0][0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        if (IRQ_EN) model_pending[0] = 1'b1;
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] d;
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        status_arr[0] = 32'h1234_5670;
        status_arr[1] = 32'hDEAD_BEEF;
        status_arr[2] = 32'h0BAD_F00D;
        status_arr[3] = 32'h55AA_55AA;
        for (int k = 0; k < NUM_RW; k++) begin exp_pulse[k] = 0; pulse_cnt[k] = 0; end
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #3;
        check("reset_awready", awready, 0);
        check("reset_wready", wready, 0);
        check("reset_arready", arready, 0);
        check("reset_bvalid", bvalid, 0);
        check("reset_rvalid", rvalid, 0);
        check("reset_rdata", rdata, 0);
        check("reset_wr_pulse", wr_pulse, 0);
        check("reset_irq", irq, 0);
        check("reset_ctrl_zero", ctrl_out == '0, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write/readback.
        for (int k = 0; k < 4; k++) write_reg(AW'(k*4), 32'(k + 1), 4'hF, 0, 0);
        for (int k = 0; k < 4; k++) read_reg(AW'(k*4));

        // Partial strobes.
        write_reg(8'h08, 32'hAABB_CCDD, 4'hF, 0, 0);
        write_reg(8'h08, 32'h1122_3344, 4'h5, 0, 0);
        check("partial_value", model_rw[2], 32'hAA22_CC44);
        read_reg(8'h08);
        write_reg(8'h0C, 32'hFFFF_FFFF, 4'h0, 0, 0);
        read_reg(8'h0D);

        // Channel ordering.
        write_reg(8'h10, 32'hA5A5_0001, 4'hF, 0, 3);
        write_reg(8'h14, 32'hA5A5_0002, 4'hF, 3, 0);
        write_reg(8'h18, 32'hA5A5_0003, 4'hF, 0, 0);

        // BVALID/BRESP held while BREADY is low.
        bready = 1'b0;
        send_write(8'h1C, 32'h0BAD_CAFE, 4'hF, 0, 0);
        begin
            int t = 0;
            while (!bvalid && t < TIMEOUT) begin @(negedge clk); t++; end
        end
        model_commit(7, 32'h0BAD_CAFE, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, OKAY);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        wait_b();
        check("pulse_after_hold", pulse_cnt[7], exp_pulse[7]);

        // Error decode.
        write_reg(AW'(NUM_RW*4), 32'hFFFF_0000, 4'hF, 0, 0);
        check_ctrl_all("ctrl_after_ro_write");
        read_reg(AW'(NUM_RW*4));
        read_reg(AW'(20*4));
        read_reg(AW'(13*4));

        // Read and write of the same register in the same cycle returns the old value.
        fork
            read_reg(8'h04);
            write_reg(8'h04, 32'h7777_8888, 4'hF, 0, 0);
        join
        read_reg(8'h04);

        // Pending-interrupt register (unmapped and irq=0 without the feature).
        pulse_status0();
        check("irq_after_edge", irq, IRQ_EN);
        read_reg(AW'(IRQ_IDX*4));
        write_reg(AW'(IRQ_IDX*4), 32'h1, 4'hF, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        check("irq_after_clear", irq, 0);
        read_reg(AW'(IRQ_IDX*4));
        pulse_status0();
        fork
            write_reg(AW'(IRQ_IDX*4), 32'h1, 4'hF, 0, 3);
            begin
                repeat (3) begin @(posedge clk); #1; end
                status_arr[0][0] = 1'b1;
            end
        join
        if (IRQ_EN) model_pending[0] = 1'b1;
        status_arr[0][0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("irq_set_wins", irq, IRQ_EN);
        read_reg(AW'(IRQ_IDX*4));
        write_reg(AW'(IRQ_IDX*4), 32'hF, 4'h1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            int op = $urandom_range(0, 2);
            if (op == 0) begin
                int idx = $urandom_range(0, IRQ_IDX + 1);
                d = $urandom;
                write_reg(AW'(idx*4 + $urandom_range(0, 3)), d, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (op == 1) begin
                int idx = $urandom_range(0, 21);
                read_reg(AW'(idx*4 + $urandom_range(0, 3)));
            end else begin
                int idx = $urandom_range(0, NUM_RW - 1);
                d = $urandom;
                fork
                    read_reg(AW'(idx*4));
                    write_reg(AW'(idx*4), d, 4'hF, 0, 0);
                join
            end
        end
        check_ctrl_all("ctrl_after_random");

        // Reset with both responses pending.
        bready = 1'b0;
        rready = 1'b0;
        d = 32'hCAFE_F00D;
        send_write(8'h00, d, 4'hF, 0, 0);
        send_ar(8'h00);
        begin
            int t = 0;
            while (!(bvalid && rvalid) && t < TIMEOUT) begin @(negedge clk); t++; end
        end
        check("pre_reset_bvalid", bvalid, 1);
        check("pre_reset_rvalid", rvalid, 1);
        model_commit(0, d, 4'hF);
        check("pre_reset_reg0", ctrl_out[DW-1:0], model_rw[0]);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset_drops_bvalid", bvalid, 0);
        check("reset_drops_rvalid", rvalid, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bready = 1'b1;
        rready = 1'b1;
        @(posedge clk); #1;
        read_reg(8'h00);
        check_ctrl_all("ctrl_after_reset");

        repeat (4) @(posedge clk);
        check("scoreboard_b_empty", exp_b.size(), 0);
        check("scoreboard_r_empty", exp_r.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
